// File: rtl/fp_cmd_pkg.sv
// Shared types and constants for the FrontPanel command responder.
// MUL support is selected at build time with FP_CMD_MUL_EN.
package fp_cmd_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned CNT_W  = 5;

  localparam logic [OP_W-1:0] OP_CLR = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_MUL = 4'h3;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_ERR     = 2;
  localparam int unsigned ST_OVR     = 3;
  localparam int unsigned ST_SEQ_LSB = 8;
  localparam int unsigned ST_SEQ_MSB = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // Pack the host-visible status word; unlisted bits read as zero.
  function automatic logic [DATA_W-1:0] make_status(input state_e st,
                                                    input logic err,
                                                    input logic ovr,
                                                    input logic [SEQ_W-1:0] seq);
    logic [DATA_W-1:0] s;
    s = '0;
    s[ST_BUSY] = (st == EXEC);
    s[ST_DONE] = (st == DONE);
    s[ST_ERR]  = err;
    s[ST_OVR]  = ovr;
    s[ST_SEQ_MSB:ST_SEQ_LSB] = seq;
    return s;
  endfunction

endpackage

// File: rtl/fp_cmd_responder_if.sv
// Wire In / Trigger In / Wire Out bundle between okHost endpoints and the responder.
// Same signal set whether or not FP_CMD_MUL_EN is defined.
interface fp_cmd_responder_if;
  import fp_cmd_pkg::*;

  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] arg_a;
  logic [DATA_W-1:0] arg_b;
  logic              trig_start;
  logic              trig_ack;
  logic [DATA_W-1:0] result_lo;
  logic [DATA_W-1:0] result_hi;
  logic [DATA_W-1:0] status;

  modport master (
    output cmd_op, arg_a, arg_b, trig_start, trig_ack,
    input  result_lo, result_hi, status
  );

  modport slave (
    input  cmd_op, arg_a, arg_b, trig_start, trig_ack,
    output result_lo, result_hi, status
  );

endinterface

// File: rtl/fp_serial_mult32.sv
// 32x32 unsigned serial shift-add multiplier, 32 iterations, done pulse on completion.
// Only present when FP_CMD_MUL_EN is defined.
`ifdef FP_CMD_MUL_EN
module fp_serial_mult32
  import fp_cmd_pkg::*;
(
  input  logic                  okClk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  done
);

  logic [DATA_W-1:0]   a_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                run_q;
  logic                done_q;

  // One shift-add step: low half holds remaining multiplier bits.
  function automatic logic [2*DATA_W-1:0] step(input logic [2*DATA_W-1:0] p,
                                               input logic [DATA_W-1:0] m);
    logic [DATA_W:0] s;
    s = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
    return {s, p[DATA_W-1:1]};
  endfunction

  // The load edge performs iteration 0 so the product lands after 32 edges.
  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      a_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q    <= a;
        prod_q <= step({{DATA_W{1'b0}}, b}, a);
        cnt_q  <= CNT_W'(1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        prod_q <= step(prod_q, a_q);
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(31)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule
`endif

// File: rtl/fp_cmd_responder.sv
// FrontPanel command responder: latch command on start, execute, hold result until ack.
// Define FP_CMD_MUL_EN to enable opcode 0x3 (serial MUL); otherwise it is illegal.
module fp_cmd_responder
  import fp_cmd_pkg::*;
(
  input  logic              okClk,
  input  logic              rst_n,
  fp_cmd_responder_if.slave bus
);

  state_e            state, state_nx;
  cmd_t              cmd_q, cmd_nx;
  logic [DATA_W-1:0] lo_q, lo_nx;
  logic [DATA_W-1:0] hi_q, hi_nx;
  logic [DATA_W-1:0] status_q, status_nx;
  logic              err_q, err_nx;
  logic              ovr_q, ovr_nx;
  logic [SEQ_W-1:0]  seq_q, seq_nx;
  logic [DATA_W:0]   add_c;

`ifdef FP_CMD_MUL_EN
  logic                mul_start_c;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  fp_serial_mult32 u_mult (
    .okClk   (okClk),
    .rst_n   (rst_n),
    .start   (mul_start_c),
    .a       (bus.arg_a),
    .b       (bus.arg_b),
    .product (mul_prod),
    .done    (mul_done)
  );
`endif

  assign add_c = {1'b0, cmd_q.a} + {1'b0, cmd_q.b};

  always_ff @(posedge okClk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus next values of every host-visible register.
  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    lo_nx    = lo_q;
    hi_nx    = hi_q;
    err_nx   = err_q;
    ovr_nx   = ovr_q;
    seq_nx   = seq_q;
`ifdef FP_CMD_MUL_EN
    mul_start_c = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.trig_start) begin
          cmd_nx.op = bus.cmd_op;
          cmd_nx.a  = bus.arg_a;
          cmd_nx.b  = bus.arg_b;
          err_nx    = 1'b0;
          state_nx  = EXEC;
`ifdef FP_CMD_MUL_EN
          mul_start_c = (bus.cmd_op == OP_MUL);
`endif
        end
      end
      EXEC: begin
        if (bus.trig_start) ovr_nx = 1'b1;
        state_nx = DONE;
        seq_nx   = seq_q + SEQ_W'(1);
        case (cmd_q.op)
          OP_CLR: begin
            lo_nx  = '0;
            hi_nx  = '0;
            ovr_nx = 1'b0;
          end
          OP_ADD: begin
            lo_nx = add_c[DATA_W-1:0];
            hi_nx = DATA_W'(add_c[DATA_W]);
          end
          OP_SUB: begin
            lo_nx = cmd_q.a - cmd_q.b;
            hi_nx = DATA_W'(cmd_q.a < cmd_q.b);
          end
`ifdef FP_CMD_MUL_EN
          OP_MUL: begin
            if (mul_done) begin
              {hi_nx, lo_nx} = mul_prod;
            end else begin
              state_nx = EXEC;
              seq_nx   = seq_q;
            end
          end
`endif
          default: err_nx = 1'b1;
        endcase
      end
      DONE: begin
        if (bus.trig_start) ovr_nx = 1'b1;
        if (bus.trig_ack)   state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    status_nx = make_status(state_nx, err_nx, ovr_nx, seq_nx);
  end

  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      seq_q    <= '0;
    end else begin
      cmd_q    <= cmd_nx;
      lo_q     <= lo_nx;
      hi_q     <= hi_nx;
      status_q <= status_nx;
      err_q    <= err_nx;
      ovr_q    <= ovr_nx;
      seq_q    <= seq_nx;
    end
  end

  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_fp_cmd_responder.sv
// Directed bench for fp_cmd_responder with a result scoreboard.
// Expectations follow FP_CMD_MUL_EN when it is defined for the build.
module tb_fp_cmd_responder;

  logic okClk = 1'b0;
  logic rst_n;

  always #5 okClk = ~okClk;

  fp_cmd_responder_if bus ();

  fp_cmd_responder dut (
    .okClk (okClk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef FP_CMD_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] st;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [31:0] m_lo  = '0;
  logic [31:0] m_hi  = '0;
  logic [7:0]  m_seq = '0;
  logic        m_err = 1'b0;
  logic        m_ovr = 1'b0;

  function automatic logic [31:0] m_status(input logic done);
    return {16'h0000, m_seq, 4'h0, m_ovr, m_err, done, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    m_err = 1'b0;
    case (op)
      4'h0: begin m_lo = '0; m_hi = '0; m_ovr = 1'b0; end
      4'h1: begin w = {32'h0, a} + {32'h0, b}; m_lo = w[31:0]; m_hi = w[63:32]; end
      4'h2: begin m_lo = a - b; m_hi = (a < b) ? 32'd1 : 32'd0; end
      4'h3: begin
        if (MUL_EN) begin
          w = {32'h0, a} * {32'h0, b};
          m_lo = w[31:0];
          m_hi = w[63:32];
        end else begin
          m_err = 1'b1;
        end
      end
      default: m_err = 1'b1;
    endcase
    m_seq = m_seq + 8'd1;
  endtask

  // Start a command; extra_start keeps start high one more edge (sampled in EXEC).
  task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit extra_start);
    exp_t e;
    int cyc;
    int exp_lat;
    bit held;
    logic [31:0] prev_lo;
    exp_lat = (op == 4'h3 && MUL_EN) ? 32 : 1;
    prev_lo = m_lo;
    @(negedge okClk);
    bus.cmd_op = op;
    bus.arg_a = a;
    bus.arg_b = b;
    bus.trig_start = 1'b1;
    @(posedge okClk);
    #1;
    if (!extra_start) bus.trig_start = 1'b0;
    chk("busy_after_start", 32'(bus.status[0]), 32'd1);
    if (extra_start) m_ovr = 1'b1;
    model_exec(op, a, b);
    e.lo = m_lo;
    e.hi = m_hi;
    e.st = m_status(1'b1);
    sb.push_back(e);
    cyc  = 0;
    held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge okClk);
      #1;
      bus.trig_start = 1'b0;
      if (bus.status[1]) begin
        cyc = i;
        break;
      end
      if (bus.result_lo !== prev_lo) held = 1'b0;
    end
    chk("done_latency", cyc, exp_lat);
    chk("result_held_while_busy", 32'(held), 32'd1);
    e = sb.pop_front();
    chk("result_lo", bus.result_lo, e.lo);
    chk("result_hi", bus.result_hi, e.hi);
    chk("status_done", bus.status, e.st);
  endtask

  task automatic do_ack();
    @(negedge okClk);
    bus.trig_ack = 1'b1;
    @(posedge okClk);
    #1;
    bus.trig_ack = 1'b0;
    chk("status_after_ack", bus.status, m_status(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cmd_op = '0;
    bus.arg_a = '0;
    bus.arg_b = '0;
    bus.trig_start = 1'b0;
    bus.trig_ack = 1'b0;
    repeat (2) @(posedge okClk);
    #1;
    chk("reset_lo", bus.result_lo, 32'h0);
    chk("reset_hi", bus.result_hi, 32'h0);
    chk("reset_status", bus.status, 32'h0);
    @(negedge okClk);
    rst_n = 1'b1;

    // ADD with carry-out, then ack
    do_cmd(4'h1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    chk("add_tp_status", bus.status, 32'h0000_0102);
    do_ack();
    chk("add_tp_ack_status", bus.status, 32'h0000_0100);

    // SUB with borrow
    do_cmd(4'h2, 32'h5, 32'h7, 1'b0);
    do_ack();

    // MUL (or illegal when MUL is not built)
    do_cmd(4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_ack();
    do_cmd(4'h1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    do_ack();

    // Illegal op keeps results, error survives ack, next legal start clears it
    do_cmd(4'h9, 32'h1, 32'h1, 1'b0);
    do_ack();
    do_cmd(4'h2, 32'h10, 32'h3, 1'b0);
    do_ack();

    // Ack in IDLE has no effect
    @(negedge okClk);
    bus.trig_ack = 1'b1;
    @(posedge okClk);
    #1;
    bus.trig_ack = 1'b0;
    chk("ack_in_idle", bus.status, m_status(1'b0));

    // Start during EXEC, then start+ack together in DONE
    do_cmd(4'h3, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
    @(negedge okClk);
    bus.cmd_op = 4'h1;
    bus.trig_start = 1'b1;
    bus.trig_ack = 1'b1;
    @(posedge okClk);
    #1;
    bus.trig_start = 1'b0;
    bus.trig_ack = 1'b0;
    m_ovr = 1'b1;
    chk("start_ack_status", bus.status, m_status(1'b0));
    repeat (3) @(posedge okClk);
    #1;
    chk("dropped_start_idle", bus.status, m_status(1'b0));
    chk("dropped_start_lo", bus.result_lo, m_lo);

    // CLR clears overrun and results
    do_cmd(4'h0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    chk("clr_status", bus.status[3:0], 32'h2);
    do_ack();

    do_cmd(4'h3, 32'h0001_0000, 32'h0003_0005, 1'b0);
    do_ack();
    do_cmd(4'h1, 32'h100, 32'h200, 1'b0);
    do_ack();

    // Reset pulse while a command is executing
    @(negedge okClk);
    bus.cmd_op = MUL_EN ? 4'h3 : 4'h1;
    bus.arg_a = 32'hCAFE_F00D;
    bus.arg_b = 32'h7777_0001;
    bus.trig_start = 1'b1;
    @(posedge okClk);
    #1;
    bus.trig_start = 1'b0;
    if (MUL_EN) repeat (5) @(posedge okClk);
    @(negedge okClk);
    rst_n = 1'b0;
    @(posedge okClk);
    #1;
    m_lo = '0; m_hi = '0; m_seq = '0; m_err = 1'b0; m_ovr = 1'b0;
    sb.delete();
    chk("midexec_reset_lo", bus.result_lo, m_lo);
    chk("midexec_reset_hi", bus.result_hi, m_hi);
    chk("midexec_reset_status", bus.status, m_status(1'b0));
    @(negedge okClk);
    rst_n = 1'b1;
    repeat (40) @(posedge okClk);
    #1;
    chk("post_reset_quiet_status", bus.status, 32'h0);
    chk("post_reset_quiet_lo", bus.result_lo, 32'h0);

    // 256 completions wrap the sequence counter
    for (int i = 0; i < 256; i++) begin
      do_cmd(4'h1, $urandom, $urandom, 1'b0);
      do_ack();
    end
    chk("seq_wrap_status", bus.status, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
